// File: rtl/slow_seq.sv
// Fast/slow CPU clock sequencer: a bus hit on an enabled slow device requests the
// slow clock, stalls until it is acknowledged, and holds it for an idle timeout.
module slow_seq #(
  parameter int TICK_DIV = 256
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       SlowAck,
  output logic       SlowReq,
  output logic       Stall,
  output logic       ClockGate,
  output logic       IsSlow
);

  // state     | meaning
  // FAST      | fast clock, no request outstanding
  // SWITCH_DN | slow clock requested, waiting for SlowAck
  // SLOW      | slow clock running, idle timeout counting
  // SWITCH_UP | request dropped, waiting for SlowAck to fall
  typedef enum logic [1:0] {FAST, SWITCH_DN, SLOW, SWITCH_UP} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [PW-1:0] presc;
  logic          slow_req_q;
  logic          is_slow_q;
  logic          hit;

  assign hit = BACT && ((IACKCS && SlowIACK) || (VIACS && SlowVIA) ||
                        (IWMCS && SlowIWM) || (SCCCS && SlowSCC) ||
                        (SCSICS && SlowSCSI) || (SndCS && SlowSnd));

  // Gated by nPOR so a pending access is released the instant reset asserts.
  assign Stall     = nPOR && hit && (state != SLOW);
  assign SlowReq   = slow_req_q;
  assign IsSlow    = is_slow_q;
  assign ClockGate = is_slow_q && SlowClockGate;

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state      <= FAST;
      cnt        <= '0;
      presc      <= '0;
      slow_req_q <= 1'b0;
      is_slow_q  <= 1'b0;
    end else begin
      case (state)
        FAST: begin
          if (hit) begin
            state      <= SWITCH_DN;
            slow_req_q <= 1'b1;
          end
        end
        SWITCH_DN: begin
          if (SlowAck) begin
            state     <= SLOW;
            is_slow_q <= 1'b1;
            cnt       <= SlowTimeout;
            presc     <= '0;
          end
        end
        SLOW: begin
          if (hit) begin
            cnt   <= SlowTimeout;
            presc <= '0;
          end else if (cnt == 4'd0) begin
            state      <= SWITCH_UP;
            slow_req_q <= 1'b0;
            is_slow_q  <= 1'b0;
          end else begin
            presc <= presc + 1'b1;
            if (presc == PRESC_MAX) cnt <= cnt - 1'b1;
          end
        end
        SWITCH_UP: begin
          if (!SlowAck) begin
            if (hit) begin
              state      <= SWITCH_DN;
              slow_req_q <= 1'b1;
            end else begin
              state <= FAST;
            end
          end
        end
        default: begin
          state      <= FAST;
          slow_req_q <= 1'b0;
          is_slow_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_seq.sv
// Directed bench for slow_seq with TICK_DIV=4; expected values are hand-derived.
module tb_slow_seq;

  logic       CLK = 1'b0;
  logic       nPOR;
  logic       BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowAck;
  logic       SlowReq, Stall, ClockGate, IsSlow;

  int errors = 0;
  int checks = 0;

  slow_seq #(.TICK_DIV(4)) dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .IACKCS(IACKCS), .VIACS(VIACS),
    .IWMCS(IWMCS), .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS),
    .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
    .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd), .SlowClockGate(SlowClockGate),
    .SlowTimeout(SlowTimeout), .SlowAck(SlowAck), .SlowReq(SlowReq),
    .Stall(Stall), .ClockGate(ClockGate), .IsSlow(IsSlow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // VIA access is the hit source used throughout (SlowVIA stays enabled)
  task automatic set_via(input logic v);
    BACT  = v;
    VIACS = v;
  endtask

  task automatic enter_slow();
    set_via(1'b1);
    tick();
    SlowAck = 1'b1;
    tick();
  endtask

  // Drop the hit right after a reload edge and count edges until IsSlow falls
  task automatic measure_exit(output int n);
    n = 0;
    tick();
    set_via(1'b0);
    #1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (!IsSlow) break;
    end
  endtask

  task automatic test_reset();
    nPOR = 1'b0;
    {BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = '0;
    {SlowIACK, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = '0;
    SlowVIA = 1'b1;
    SlowClockGate = 1'b0;
    SlowTimeout = 4'd3;
    SlowAck = 1'b0;
    tick();
    set_via(1'b1);
    #1;
    checks++;
    if ({SlowReq, Stall, ClockGate, IsSlow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {SlowReq, Stall, ClockGate, IsSlow});
    end
    set_via(1'b0);
    tick();
    nPOR = 1'b1;
    tick();
    checks++;
    if ({SlowReq, IsSlow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got %b expected 00", {SlowReq, IsSlow});
    end
  endtask

  task automatic test_slow_entry();
    int stall_cycles;
    set_via(1'b1);
    #1;
    checks++;
    if (Stall !== 1'b1 || SlowReq !== 1'b0) begin
      errors++;
      $display("FAIL entry_hit: stall=%b req=%b expected 1 0", Stall, SlowReq);
    end
    tick();
    checks++;
    if (SlowReq !== 1'b1 || IsSlow !== 1'b0) begin
      errors++;
      $display("FAIL entry_req: req=%b slow=%b expected 1 0", SlowReq, IsSlow);
    end
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (Stall === 1'b1) stall_cycles++;
      if (i == 2) SlowAck = 1'b1;
      tick();
    end
    checks++;
    if (stall_cycles != 3) begin
      errors++;
      $display("FAIL entry_stall_len: got %0d expected 3", stall_cycles);
    end
    checks++;
    if (IsSlow !== 1'b1 || Stall !== 1'b0 || SlowReq !== 1'b1) begin
      errors++;
      $display("FAIL entry_slow: slow=%b stall=%b req=%b expected 1 0 1", IsSlow, Stall, SlowReq);
    end
  endtask

  task automatic test_timeout();
    int n;
    measure_exit(n);
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL timeout3_exit: got %0d edges expected 13", n);
    end
    checks++;
    if (SlowReq !== 1'b0 || ClockGate !== 1'b0) begin
      errors++;
      $display("FAIL switch_up_outs: req=%b gate=%b expected 0 0", SlowReq, ClockGate);
    end
    SlowAck = 1'b0;
    tick();
    tick();
    checks++;
    if ({SlowReq, IsSlow, Stall} !== 3'b000) begin
      errors++;
      $display("FAIL back_to_fast: got %b expected 000", {SlowReq, IsSlow, Stall});
    end
  endtask

  task automatic test_not_enabled();
    int req_seen = 0;
    int stall_seen = 0;
    SlowSCSI = 1'b0;
    BACT = 1'b1;
    SCSICS = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (Stall !== 1'b0) stall_seen++;
      tick();
      if (SlowReq !== 1'b0) req_seen++;
    end
    BACT = 1'b0;
    SCSICS = 1'b0;
    checks++;
    if (req_seen != 0 || stall_seen != 0) begin
      errors++;
      $display("FAIL scsi_disabled: req_cycles=%0d stall_cycles=%0d expected 0 0", req_seen, stall_seen);
    end
  endtask

  task automatic test_periodic_hits();
    int left_slow = 0;
    int n;
    SlowClockGate = 1'b1;
    enter_slow();
    set_via(1'b0);
    checks++;
    if (ClockGate !== 1'b1) begin
      errors++;
      $display("FAIL gate_in_slow: got %b expected 1", ClockGate);
    end
    for (int k = 0; k < 5; k++) begin
      set_via(1'b1);
      #1;
      if (Stall !== 1'b0) left_slow++;
      tick();
      set_via(1'b0);
      for (int j = 0; j < 9; j++) begin
        tick();
        if (IsSlow !== 1'b1) left_slow++;
      end
    end
    checks++;
    if (left_slow != 0) begin
      errors++;
      $display("FAIL periodic_hold: bad cycles=%0d expected 0", left_slow);
    end
    set_via(1'b1);
    measure_exit(n);
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL periodic_reload: got %0d edges expected 13", n);
    end
    checks++;
    if (ClockGate !== 1'b0) begin
      errors++;
      $display("FAIL gate_switch_up: got %b expected 0", ClockGate);
    end
  endtask

  // Entered with state SWITCH_UP and SlowAck still high
  task automatic test_hit_in_switch_up();
    set_via(1'b1);
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL up_hit_stall: got %b expected 1", Stall);
    end
    tick();
    checks++;
    if (SlowReq !== 1'b0 || Stall !== 1'b1) begin
      errors++;
      $display("FAIL up_wait: req=%b stall=%b expected 0 1", SlowReq, Stall);
    end
    SlowAck = 1'b0;
    tick();
    checks++;
    if (SlowReq !== 1'b1 || Stall !== 1'b1 || IsSlow !== 1'b0) begin
      errors++;
      $display("FAIL up_to_dn: req=%b stall=%b slow=%b expected 1 1 0", SlowReq, Stall, IsSlow);
    end
    SlowAck = 1'b1;
    tick();
    checks++;
    if (IsSlow !== 1'b1 || Stall !== 1'b0 || ClockGate !== 1'b1) begin
      errors++;
      $display("FAIL up_reslow: slow=%b stall=%b gate=%b expected 1 0 1", IsSlow, Stall, ClockGate);
    end
  endtask

  task automatic test_timeout_zero();
    int n;
    SlowTimeout = 4'd0;
    measure_exit(n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL timeout0_exit: got %0d edges expected 1", n);
    end
    SlowAck = 1'b0;
    tick();
    SlowTimeout = 4'd3;
  endtask

  task automatic test_spurious_ack();
    SlowAck = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({SlowReq, IsSlow, ClockGate} !== 3'b000) begin
      errors++;
      $display("FAIL spurious_ack: got %b expected 000", {SlowReq, IsSlow, ClockGate});
    end
    SlowAck = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_switch();
    set_via(1'b1);
    tick();
    checks++;
    if (SlowReq !== 1'b1) begin
      errors++;
      $display("FAIL mid_dn_req: got %b expected 1", SlowReq);
    end
    #2;
    nPOR = 1'b0;
    #1;
    checks++;
    if ({SlowReq, Stall, ClockGate, IsSlow} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", {SlowReq, Stall, ClockGate, IsSlow});
    end
    set_via(1'b0);
    tick();
    nPOR = 1'b1;
    tick();
    checks++;
    if ({SlowReq, IsSlow} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_fast: got %b expected 00", {SlowReq, IsSlow});
    end
    set_via(1'b1);
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_stall: got %b expected 1", Stall);
    end
    tick();
    checks++;
    if (SlowReq !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_req: got %b expected 1", SlowReq);
    end
    set_via(1'b0);
  endtask

  initial begin
    test_reset();
    test_slow_entry();
    test_timeout();
    test_not_enabled();
    test_periodic_hits();
    test_hit_in_switch_up();
    test_timeout_zero();
    test_spurious_ack();
    test_reset_mid_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
